// File: rtl/nco_lut_arbiter.sv
// nco_lut_arbiter: round-robin arbiter that shares a dual-read-port quarter-wave
// sine LUT between several NCO phase requesters. Up to two requests per cycle
// are granted (low port first, high port second). Each phase word is folded
// into a quarter-wave index plus sign. The registered LUT words are routed back
// to the requesting channel through a two-stage tag pipeline.
module nco_lut_arbiter #(
  parameter int LUT_Size          = 8,
  parameter int Output_Resolution = 16,
  parameter int Num_Channels      = 4
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [Num_Channels-1:0]                     req,
  input  logic [Num_Channels*(LUT_Size+2)-1:0]        phase,
  output logic [Num_Channels-1:0]                     ack,
  output logic [LUT_Size-1:0]                         index_low,
  output logic [LUT_Size-1:0]                         index_high,
  output logic                                        sign_low,
  output logic                                        sign_high,
  input  logic [Output_Resolution:0]                  lut_value_low,
  input  logic [Output_Resolution:0]                  lut_value_high,
  output logic [Num_Channels-1:0]                     result_valid,
  output logic [Num_Channels*(Output_Resolution+1)-1:0] result_value
);

  localparam int PW = LUT_Size + 2;
  localparam int RW = Output_Resolution + 1;
  localparam int CW = (Num_Channels > 1) ? $clog2(Num_Channels) : 1;

  genvar gi;

  // Channel reached by stepping 'offset' places from 'base', wrapping at Num_Channels
  function automatic logic [CW-1:0] chan_at(input logic [CW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= Num_Channels) sum = sum - Num_Channels;
    return CW'(sum);
  endfunction

  // Per-channel quarter-wave fold of the phase word
  logic [LUT_Size-1:0] fold_index [Num_Channels];
  logic                fold_sign  [Num_Channels];

  generate
    for (gi = 0; gi < Num_Channels; gi++) begin : g_fold
      logic [PW-1:0] ph;
      assign ph             = phase[gi*PW +: PW];
      // Odd quadrants run the table backwards; the upper half-wave is negated
      assign fold_sign[gi]  = ph[PW-1];
      assign fold_index[gi] = ph[PW-2] ? ~ph[LUT_Size-1:0] : ph[LUT_Size-1:0];
    end
  endgenerate

  // Registered state
  logic [Num_Channels-1:0] ack_reg;
  logic [CW-1:0]           ptr_reg;
  logic [LUT_Size-1:0]     index_low_reg, index_high_reg;
  logic                    sign_low_reg, sign_high_reg;
  logic                    tag1_valid_low, tag1_valid_high;
  logic [CW-1:0]           tag1_ch_low, tag1_ch_high;
  logic                    tag2_valid_low, tag2_valid_high;
  logic [CW-1:0]           tag2_ch_low, tag2_ch_high;

  // Arbitration results
  logic [Num_Channels-1:0] eligible;
  logic                    grant_low_valid, grant_high_valid;
  logic [CW-1:0]           grant_low_ch, grant_high_ch;
  logic [CW-1:0]           ptr_next;
  logic [Num_Channels-1:0] ack_next;

  // A channel acked this cycle is still showing its old request; mask it out
  assign eligible = req & ~ack_reg;

  // Round-robin scan from ptr: first hit to the low port, second to the high port
  always_comb begin
    grant_low_valid  = 1'b0;
    grant_high_valid = 1'b0;
    grant_low_ch     = '0;
    grant_high_ch    = '0;
    for (int k = 0; k < Num_Channels; k++) begin
      if (eligible[chan_at(ptr_reg, k)]) begin
        if (!grant_low_valid) begin
          grant_low_valid = 1'b1;
          grant_low_ch    = chan_at(ptr_reg, k);
        end else if (!grant_high_valid) begin
          grant_high_valid = 1'b1;
          grant_high_ch    = chan_at(ptr_reg, k);
        end
      end
    end
  end

  // Pointer moves just past the last channel granted, or holds when idle
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_high_valid)     ptr_next = chan_at(grant_high_ch, 1);
    else if (grant_low_valid) ptr_next = chan_at(grant_low_ch, 1);
  end

  generate
    for (gi = 0; gi < Num_Channels; gi++) begin : g_ack
      assign ack_next[gi] = (grant_low_valid  && (grant_low_ch  == CW'(gi))) ||
                            (grant_high_valid && (grant_high_ch == CW'(gi)));
    end
  endgenerate

  // Grant stage: ack, LUT addresses, stage-1 tags and pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_reg         <= '0;
      ptr_reg         <= '0;
      index_low_reg   <= '0;
      index_high_reg  <= '0;
      sign_low_reg    <= 1'b0;
      sign_high_reg   <= 1'b0;
      tag1_valid_low  <= 1'b0;
      tag1_valid_high <= 1'b0;
      tag1_ch_low     <= '0;
      tag1_ch_high    <= '0;
    end else begin
      ack_reg         <= ack_next;
      ptr_reg         <= ptr_next;
      tag1_valid_low  <= grant_low_valid;
      tag1_valid_high <= grant_high_valid;
      tag1_ch_low     <= grant_low_ch;
      tag1_ch_high    <= grant_high_ch;
      // An unused port keeps its previous address and sign
      if (grant_low_valid) begin
        index_low_reg <= fold_index[grant_low_ch];
        sign_low_reg  <= fold_sign[grant_low_ch];
      end
      if (grant_high_valid) begin
        index_high_reg <= fold_index[grant_high_ch];
        sign_high_reg  <= fold_sign[grant_high_ch];
      end
    end
  end

  // Stage-2 tags line up with the LUT's registered output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag2_valid_low  <= 1'b0;
      tag2_valid_high <= 1'b0;
      tag2_ch_low     <= '0;
      tag2_ch_high    <= '0;
    end else begin
      tag2_valid_low  <= tag1_valid_low;
      tag2_valid_high <= tag1_valid_high;
      tag2_ch_low     <= tag1_ch_low;
      tag2_ch_high    <= tag1_ch_high;
    end
  end

  generate
    for (gi = 0; gi < Num_Channels; gi++) begin : g_result
      logic          valid_reg;
      logic [RW-1:0] value_reg;
      logic          hit_low, hit_high;

      assign hit_low  = tag2_valid_low  && (tag2_ch_low  == CW'(gi));
      assign hit_high = tag2_valid_high && (tag2_ch_high == CW'(gi));

      // Capture this channel's LUT word from whichever port carried it
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg <= 1'b0;
          value_reg <= '0;
        end else begin
          valid_reg <= hit_low || hit_high;
          if (hit_low)       value_reg <= lut_value_low;
          else if (hit_high) value_reg <= lut_value_high;
        end
      end

      assign result_valid[gi]          = valid_reg;
      assign result_value[gi*RW +: RW] = value_reg;
    end
  endgenerate

  assign ack        = ack_reg;
  assign index_low  = index_low_reg;
  assign index_high = index_high_reg;
  assign sign_low   = sign_low_reg;
  assign sign_high  = sign_high_reg;

endmodule

// File: doc/nco_lut_arbiter.md
# nco_lut_arbiter

Round-robin arbiter and quarter-wave address sequencer that shares the dual-read-port sine LUT between `Num_Channels` NCO phase requesters. Each cycle it grants up to two pending requests, folds each full-wave phase word into a quarter-wave LUT index and sign, drives the LUT's low and high ports, and routes each registered LUT result back to the channel that asked for it. It sits between the per-channel phase accumulators and the LUT.

## Interface
- `LUT_Size`, 8: LUT address width; phase word is `LUT_Size+2` bits.
- `Output_Resolution`, 16: LUT magnitude width; signed results are `Output_Resolution+1` bits.
- `Num_Channels`, 4: number of requesters, at least 2.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in `Num_Channels`: per-channel request, level, held until `ack`.
- `phase` in `Num_Channels*(LUT_Size+2)`: channel c phase at bits `[c*(LUT_Size+2) +: LUT_Size+2]`, stable while `req[c]` is high.
- `ack` out `Num_Channels`: one-cycle pulse, request accepted.
- `index_low`, `index_high` out `LUT_Size`: LUT port addresses.
- `sign_low`, `sign_high` out 1: LUT negate controls.
- `lut_value_low`, `lut_value_high` in `Output_Resolution+1`: registered LUT outputs, two's complement.
- `result_valid` out `Num_Channels`: one-cycle pulse, new result for channel c.
- `result_value` out `Num_Channels*(Output_Resolution+1)`: per-channel result register, same packing as `phase`, holds until overwritten.

## Operation
- Folding: `q = phase[MSB:MSB-1]`, `a = phase[LUT_Size-1:0]`.
  - q=0: index `a`, sign 0.
  - q=1: index `~a` (that is, `2^LUT_Size-1-a`), sign 0.
  - q=2: index `a`, sign 1.
  - q=3: index `~a`, sign 1.
- Eligibility: `req[c]` is high and `ack[c]` is low in the current cycle. Masking on `ack` prevents a double grant while the requester drops `req`.
- Round-robin: scan eligible channels starting at pointer `ptr`, wrapping modulo `Num_Channels`.
  - The first hit is granted to the low port, the second to the high port.
  - At most two grants per cycle.
- Pointer update:
  - `ptr <= (last granted channel + 1) mod Num_Channels`.
  - If nothing is granted, `ptr` holds.
- Unused port: its index and sign registers hold their previous values, and its tag valid bit is 0.
- Tag pipeline: each port carries a valid bit plus a channel ID, delayed to align with LUT latency.
- Result writeback: on a valid tag, `result_value[ch] <=` that port's `lut_value`, and `result_valid[ch]` pulses. The low and high ports always carry distinct channels, so writes never collide.
- Zero magnitude with sign 1 yields 0; there is no special case.
- Reset (asynchronous, `reset_n` low):
  - `ack`, `index_*`, `sign_*`, `result_valid`, `result_value`, `ptr` and all tag valids clear to 0.
  - In-flight lookups are discarded and produce no `result_valid` after release.
  - The LUT itself has no reset; its stale outputs are ignored because the tags are invalid.

## Timing
- E0: request sampled and arbitrated combinationally. Registered updates are `ack`, `index_*`, `sign_*`, tag stage 1 and `ptr`.
- Cycle after E0: `ack[c]` is high and the LUT addresses are driven.
- E1: LUT registers its outputs; tags advance to stage 2.
- E2: `result_value[c]` is written and `result_valid[c]` goes high for the cycle after E2.
- Latency: `result_valid` asserts 2 cycles after `ack`, 3 edges after the request is sampled.
- Throughput:
  - Two lookups per cycle sustained.
  - The same channel is re-granted at most every 2 cycles, due to `ack` masking.
- A requester must deassert `req` or present a new phase in the cycle it sees `ack`. If `req` is still high the cycle after `ack`, that counts as a new request.
- Reset deasserted mid-stream: arbitration resumes on the first edge with `reset_n` high, `ptr` = 0.

## Test plan
(N=4, `LUT_Size`=8, LUT preloaded with known values `rom[]`.)
- Reset: hold `reset_n` low with `req`=4'hF -> all outputs 0, no `ack`. Release -> first edge grants ch0 low, ch1 high.
- Single lookup: `req[2]`, phase 10'h040 -> `ack[2]` next cycle, `index_low`=8'h40, `sign_low`=0. Two cycles later `result_valid[2]` pulses and `result_value[2]` = `{0,rom[8'h40]}`.
- Folding: phases 10'h140, 10'h240, 10'h3FF -> index/sign 8'hBF/0, 8'h40/1, 8'h00/1. Results are `+rom[8'hBF]`, `-rom[8'h40]`, `-rom[0]`.
- Contention: all four channels re-request immediately after each `ack`, with `ptr`=0 -> grants alternate {0,1}, {2,3}, {0,1}…. Two `result_valid` bits per cycle in steady state, each carrying the correct channel's value.
- Wrap: `ptr`=1 with only ch3 and ch0 requesting -> ch3 on the low port, ch0 on the high port, then `ptr`=1.
- Reset mid-flight: assert `reset_n` low one cycle after an `ack` -> no `result_valid` ever appears for that lookup, and `result_value` reads 0.
